// File: rtl/ble_ack_parser.sv
// Pulls bytes from a first-word-fall-through UART RX FIFO, assembles CR/LF lines
// and classifies each as OK / ERROR / UNKNOWN with single-cycle pulses.
module ble_ack_parser #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int MAX_LINE        = 32,
  parameter int IDLE_GAP_CYCLES = 104_167
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_rd_en,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic       ok_found,
  output logic       error_found,
  output logic [5:0] line_len,
  output logic       overflow,
  output logic       gap_flush,
  output logic       busy
);

  localparam int              GW       = $clog2(IDLE_GAP_CYCLES + 1);
  localparam logic [5:0]      MAX_L    = 6'(MAX_LINE);
  localparam logic [GW-1:0]   GAP_LAST = GW'(IDLE_GAP_CYCLES - 1);
  localparam logic [7:0]      CH_CR    = 8'h0D;
  localparam logic [7:0]      CH_LF    = 8'h0A;

  if (MAX_LINE < 5 || MAX_LINE > 63 || CLK_FREQ_HZ <= 0 || IDLE_GAP_CYCLES < 1) begin : g_bad_param
    $error("ble_ack_parser: unsupported parameter values");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    POP,
    SETTLE,
    REPORT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_buf [MAX_LINE];
  logic [5:0]      r_len;
  logic [GW-1:0]   r_gap;
  logic            r_ovf_line;
  logic            r_lf;
  logic            r_en_d;
  logic            r_resp_valid;
  logic [1:0]      r_code;
  logic            r_ok;
  logic            r_err;
  logic [5:0]      r_line_len;
  logic            r_overflow;
  logic            r_gap_flush;
  logic            w_is_ok;
  logic            w_is_err;

  always_comb begin
    w_next   = r_state;
    rx_rd_en = 1'b0;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_next = WAIT_BYTE;
        WAIT_BYTE: if (rx_valid) w_next = POP;
        POP:       w_next = SETTLE;
        SETTLE:    w_next = r_lf ? REPORT : WAIT_BYTE;
        REPORT:    w_next = WAIT_BYTE;
        default:   w_next = IDLE;
      endcase
    end
    // The pop is committed once POP is entered, even if enable drops now.
    if (r_state == POP && rx_valid) rx_rd_en = 1'b1;
  end

  always_comb begin
    w_is_ok  = !r_ovf_line && r_len == 6'd2 &&
               r_buf[0] == 8'h4F && r_buf[1] == 8'h4B;
    w_is_err = !r_ovf_line && r_len == 6'd5 &&
               r_buf[0] == 8'h45 && r_buf[1] == 8'h52 && r_buf[2] == 8'h52 &&
               r_buf[3] == 8'h4F && r_buf[4] == 8'h52;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_gap        <= '0;
      r_ovf_line   <= 1'b0;
      r_lf         <= 1'b0;
      r_en_d       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_code       <= '0;
      r_ok         <= 1'b0;
      r_err        <= 1'b0;
      r_line_len   <= '0;
      r_overflow   <= 1'b0;
      r_gap_flush  <= 1'b0;
      for (int unsigned i = 0; i < MAX_LINE; i++) r_buf[i] <= '0;
    end else begin
      r_state      <= w_next;
      r_en_d       <= enable;
      r_resp_valid <= 1'b0;
      r_ok         <= 1'b0;
      r_err        <= 1'b0;
      r_gap_flush  <= 1'b0;
      if (enable && !r_en_d) r_overflow <= 1'b0;

      if (!enable) begin
        r_len      <= '0;
        r_gap      <= '0;
        r_ovf_line <= 1'b0;
        r_lf       <= 1'b0;
      end else begin
        case (r_state)
          WAIT_BYTE: begin
            if (rx_valid || r_len == '0) begin
              r_gap <= '0;
            end else if (r_gap == GAP_LAST) begin
              r_gap_flush <= 1'b1;
              r_len       <= '0;
              r_gap       <= '0;
              r_ovf_line  <= 1'b0;
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
          POP: begin
            r_gap <= '0;
            r_lf  <= rx_valid && rx_byte == CH_LF;
            if (rx_valid && rx_byte != CR_OR_LF_GUARD(rx_byte)) begin
              if (r_len < MAX_L) begin
                for (int unsigned i = 0; i < MAX_LINE; i++)
                  if (r_len == 6'(i)) r_buf[i] <= rx_byte;
                r_len <= r_len + 6'd1;
              end else begin
                r_overflow <= 1'b1;
                r_ovf_line <= 1'b1;
              end
            end
          end
          // Report registers load here so they are valid during the REPORT cycle.
          SETTLE: begin
            if (r_lf && r_len != '0) begin
              r_resp_valid <= 1'b1;
              r_line_len   <= r_len;
              r_ok         <= w_is_ok;
              r_err        <= w_is_err;
              r_code       <= w_is_ok ? 2'b01 : (w_is_err ? 2'b10 : 2'b11);
            end
          end
          REPORT: begin
            r_len      <= '0;
            r_gap      <= '0;
            r_ovf_line <= 1'b0;
            r_lf       <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Returns a value guaranteed to differ from b unless b is CR or LF.
  function automatic logic [7:0] CR_OR_LF_GUARD(input logic [7:0] b);
    return (b == CH_CR || b == CH_LF) ? b : ~b;
  endfunction

  assign resp_valid  = r_resp_valid;
  assign resp_code   = r_code;
  assign ok_found    = r_ok;
  assign error_found = r_err;
  assign line_len    = r_line_len;
  assign overflow    = r_overflow;
  assign gap_flush   = r_gap_flush;
  assign busy        = (r_len != '0);

endmodule

// File: tb/tb_ble_ack_parser.sv
// Directed bench for ble_ack_parser: a FIFO model feeds byte strings, a table of
// single-line vectors is checked in a loop, then multi-cycle corner cases by hand.
module tb_ble_ack_parser;

  localparam int GAP = 60;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_rd_en;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic       ok_found;
  logic       error_found;
  logic [5:0] line_len;
  logic       overflow;
  logic       gap_flush;
  logic       busy;

  ble_ack_parser #(
    .CLK_FREQ_HZ    (50_000_000),
    .MAX_LINE       (32),
    .IDLE_GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_rd_en   (rx_rd_en),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .ok_found   (ok_found),
    .error_found(error_found),
    .line_len   (line_len),
    .overflow   (overflow),
    .gap_flush  (gap_flush),
    .busy       (busy)
  );

  typedef struct {
    string txt;
    int    resp;
    int    code;
    int    len;
    int    ok;
    int    err;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] fifo[$];
  logic [7:0] tmp;
  logic       pop_pend;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_pop, n_resp, n_ok, n_err, n_flush, lf_cyc, resp_cyc;
  int bad_coh = 0;
  int bad_rd = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_pop = 0; n_resp = 0; n_ok = 0; n_err = 0; n_flush = 0;
    lf_cyc = -1; resp_cyc = -100;
  endtask

  // One clock: retire a pop issued last cycle, sample outputs, present FIFO head.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (pop_pend && fifo.size() != 0) tmp = fifo.pop_front();
    if (rx_rd_en) begin
      n_pop++;
      if (!rx_valid) bad_rd++;
      if (rx_byte == 8'h0A) lf_cyc = cyc;
    end
    if (resp_valid) begin
      n_resp++;
      resp_cyc = cyc;
    end
    if (ok_found) n_ok++;
    if (error_found) n_err++;
    if (ok_found && !(resp_valid && resp_code == 2'b01)) bad_coh++;
    if (error_found && !(resp_valid && resp_code == 2'b10)) bad_coh++;
    if (gap_flush) n_flush++;
    pop_pend = rx_rd_en;
    rx_valid = (fifo.size() != 0);
    rx_byte  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input string s);
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (fifo.size() != 0 && k < 3000) begin
      cycle();
      k++;
    end
    chk("fifo_drained", fifo.size(), 0);
    repeat (6) cycle();
  endtask

  initial begin
    vecs[0] = '{"OK\015\012",      1, 1, 2, 1, 0};
    vecs[1] = '{"ERROR\015\012",   1, 2, 5, 0, 1};
    vecs[2] = '{"\015\012",        0, 2, 5, 0, 0};
    vecs[3] = '{"ok\015\012",      1, 3, 2, 0, 0};
    vecs[4] = '{"OKAY\015\012",    1, 3, 4, 0, 0};
    vecs[5] = '{"OK\012",          1, 1, 2, 1, 0};
    vecs[6] = '{"OK \015\012",     1, 3, 3, 0, 0};
    vecs[7] = '{"ERRORS\015\012",  1, 3, 6, 0, 0};
    vecs[8] = '{"ERROR\012",       1, 2, 5, 0, 1};

    rst = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; pop_pend = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rx_rd_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_code", resp_code, 0);
    chk("rst_ok", ok_found, 0);
    chk("rst_err", error_found, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_gap_flush", gap_flush, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cycle();
    enable = 1'b1;
    repeat (2) cycle();

    for (int v = 0; v < 9; v++) begin
      clr();
      push(vecs[v].txt);
      drain();
      chk($sformatf("v%0d_pops", v), n_pop, vecs[v].txt.len());
      chk($sformatf("v%0d_resp", v), n_resp, vecs[v].resp);
      chk($sformatf("v%0d_code", v), resp_code, vecs[v].code);
      chk($sformatf("v%0d_len", v), line_len, vecs[v].len);
      chk($sformatf("v%0d_ok", v), n_ok, vecs[v].ok);
      chk($sformatf("v%0d_err", v), n_err, vecs[v].err);
      chk($sformatf("v%0d_busy", v), busy, 0);
      if (vecs[v].resp != 0) chk($sformatf("v%0d_latency", v), resp_cyc - lf_cyc, 2);
    end

    // Exactly MAX_LINE payload bytes: stored in full, no overflow.
    clr();
    for (int i = 0; i < 32; i++) fifo.push_back(8'h41);
    push("\015\012");
    drain();
    chk("full_resp", n_resp, 1);
    chk("full_code", resp_code, 3);
    chk("full_len", line_len, 32);
    chk("full_overflow", overflow, 0);

    // 40 bytes: saturates at 32 and sets sticky overflow.
    clr();
    for (int i = 0; i < 40; i++) fifo.push_back(8'h41);
    push("\015\012");
    drain();
    chk("ovf_pops", n_pop, 42);
    chk("ovf_resp", n_resp, 1);
    chk("ovf_code", resp_code, 3);
    chk("ovf_len", line_len, 32);
    chk("ovf_flag", overflow, 1);
    enable = 1'b0;
    repeat (3) cycle();
    chk("ovf_hold_en_low", overflow, 1);
    chk("code_hold_en_low", resp_code, 3);
    enable = 1'b1;
    repeat (2) cycle();
    chk("ovf_cleared", overflow, 0);

    // Idle gap flushes a partial line.
    clr();
    push("OK");
    drain();
    chk("gap_busy_before", busy, 1);
    chk("gap_no_early_flush", n_flush, 0);
    repeat (GAP + 10) cycle();
    chk("gap_flush_pulses", n_flush, 1);
    chk("gap_busy_after", busy, 0);
    chk("gap_no_resp", n_resp, 0);
    clr();
    push("ERROR\015\012");
    drain();
    chk("gap_next_resp", n_resp, 1);
    chk("gap_next_code", resp_code, 2);
    chk("gap_next_err", n_err, 1);

    // enable drop mid-line discards the partial line.
    clr();
    push("ERR");
    drain();
    chk("en_busy_before", busy, 1);
    enable = 1'b0;
    repeat (2) cycle();
    chk("en_busy_after", busy, 0);
    enable = 1'b1;
    cycle();
    push("OR\015\012");
    drain();
    chk("en_resp", n_resp, 1);
    chk("en_code", resp_code, 3);
    chk("en_len", line_len, 2);

    // Asynchronous reset mid-line.
    clr();
    push("ER");
    drain();
    chk("rstmid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_code", resp_code, 0);
    chk("rstmid_len", line_len, 0);
    chk("rstmid_rd_en", rx_rd_en, 0);
    fifo.delete();
    pop_pend = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    clr();
    push("OK\015\012");
    drain();
    chk("rstmid_next_resp", n_resp, 1);
    chk("rstmid_next_code", resp_code, 1);
    chk("rstmid_next_len", line_len, 2);
    chk("rstmid_next_ok", n_ok, 1);

    chk("pulse_coherence", bad_coh, 0);
    chk("rd_en_without_valid", bad_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
